msg_sim_scheduler: RTL
======================

# msg_sim_scheduler

Sequencer for the message-transmit simulation generator. Issues a configurable number of simulated frames at a fixed start-to-start period, driving the generator's level enable and waiting for its done pulse. Supplies the per-frame frame counter and data channel, rotating through the set bits of a channel mask. An optional watchdog aborts a frame whose done pulse never arrives. Sits between the register/control layer and the generator; all other frame fields pass straight through and are not handled here.

## Interface
- TIMEOUT_CYC, 4096: maximum cycles in RUN before abort (watchdog build only).
- PERIOD_W, 32: width of the period counter.
- sys_clk_i  in  1  system clock; single clock domain.
- rst_n_i  in  1  reset, asynchronous and active-low.
- cfg_start_i  in  1  one-cycle start pulse; honoured in IDLE only.
- cfg_stop_i  in  1  one-cycle graceful stop pulse.
- cfg_frame_num_i  in  16  frames to send; 0 = continuous until stop.
- cfg_period_i  in  PERIOD_W  start-to-start period in cycles.
- cfg_chan_mask_i  in  8  channels to rotate through; bit n = channel n.
- cfg_frame_cnt_init_i  in  16  first frame counter value.
- msg_state_done_pluse_i  in  1  generator done pulse.
- msg_sim_en_o  out  1  generator enable (level).
- sim_frame_cnt_o  out  16  frame counter for the current frame.
- sim_data_channel_o  out  8  channel number (0..7) for the current frame.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse when a sequence ends.
- cfg_err_o  out  1  sticky; start requested with mask = 0.
- timeout_err_o  out  1  sticky watchdog abort flag.

## Operation
- States: IDLE, RUN, GAP, FINISH.
- IDLE: on start with mask ≠ 0, latch all cfg_* inputs, clear both error flags, set the sent count to 0, set the channel to the lowest set mask bit, then go to RUN.
- IDLE: on start with mask = 0, set cfg_err_o and stay in IDLE.
- IDLE: if start and stop arrive in the same cycle, stop wins and nothing happens.
- RUN: msg_sim_en_o = 1. On a done pulse:
  - msg_sim_en_o = 0 and the sent count increments.
  - The frame counter increments, wrapping 0xFFFF → 0x0000.
  - The channel advances to the next set mask bit above the current one, wrapping to the lowest set bit.
  - Go to FINISH if the sent count equals a nonzero frame_num or a stop is pending; otherwise go to GAP.
- GAP: wait until the period counter reaches period−1, then go to RUN. The period counter is cleared on each RUN entry.
- GAP: a stop goes to FINISH immediately.
- Stop during RUN is recorded as pending; the current frame completes first.
- Start received while busy is ignored.
- FINISH: done_o = 1 for one cycle, then IDLE.
- Done pulse in IDLE, GAP or FINISH is ignored.
- Reset (asserted at any time): state IDLE, all outputs 0. A mid-frame reset drops msg_sim_en_o asynchronously.

## Timing
- Start sampled at cycle 0 → msg_sim_en_o high at cycle 1, with counter and channel outputs already valid.
- Done pulse at cycle k → msg_sim_en_o low at cycle k+1, updated counter and channel at cycle k+1.
- Next enable rise occurs at max(previous rise + period, k+2): enable is always low for at least one cycle between frames.
- Final frame: done_o high at cycle k+1, busy_o low at cycle k+2.
- sim_frame_cnt_o and sim_data_channel_o stay stable while msg_sim_en_o is high.

## Configuration
- MSG_SIM_SCHED_TIMEOUT_EN defined:
  - A RUN-cycle counter runs during each frame.
  - If it reaches TIMEOUT_CYC with no done pulse, msg_sim_en_o drops the next cycle, timeout_err_o is set, and the block goes to FINISH (done_o pulses).
- Macro undefined: timeout_err_o is tied to 0 and RUN waits indefinitely.

## Structure
- Package msg_sim_pkg holds:
  - the state enum;
  - TIMEOUT_CYC default;
  - channel mask width (8).
- Sub-module msg_sim_chan_rr: combinational next-set-bit-with-wrap finder; inputs mask and current channel, output next channel.

## Test plan
- Single frame: frame_num=1, mask=0x01, init=0x1234, period=100, done at 20 cycles after enable rise → enable high 20 cycles, done_o one cycle later, counter then reads 0x1235.
- Rotation: mask=0x25, frame_num=4 → channels 0, 2, 5, 0.
- Period, long: period=50 with done after 10 cycles → enable rises exactly every 50 cycles.
- Period, short: period=5 with done after 10 cycles → enable low exactly one cycle between frames.
- Stop and wrap: continuous mode, init=0xFFFF, stop mid-RUN of frame 2 → counter 0xFFFF then 0x0000, frame 2 completes, done_o pulses, no third enable.
- Errors:
  - mask=0 start → cfg_err_o=1, busy_o stays 0.
  - With MSG_SIM_SCHED_TIMEOUT_EN and TIMEOUT_CYC=64, no done pulse → enable drops after 64 cycles, timeout_err_o=1, done_o pulses.

Source files
------------

// File: rtl/msg_sim_pkg.sv
// msg_sim_pkg - shared types and constants for the message-sim scheduler (rev 1.0)
`default_nettype none

package msg_sim_pkg;

  localparam int CHAN_W          = 8;
  localparam int CHAN_IDX_W      = $clog2(CHAN_W);
  localparam int TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_GAP    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/msg_sim_chan_rr.sv
// msg_sim_chan_rr - next set mask bit strictly above cur_chan, wrapping to the lowest (rev 1.0)
`default_nettype none

module msg_sim_chan_rr
  import msg_sim_pkg::*;
(
  input  logic [CHAN_W-1:0]     mask,
  input  logic [CHAN_IDX_W-1:0] cur_chan,
  output logic [CHAN_IDX_W-1:0] next_chan
);

  logic [CHAN_IDX_W-1:0] idx;
  logic                  found;

  // Offset CHAN_W wraps back onto cur_chan, so a single-bit mask selects itself.
  always_comb begin
    next_chan = cur_chan;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= CHAN_W; i++) begin
      idx = cur_chan + CHAN_IDX_W'(i);
      if (!found && mask[idx]) begin
        next_chan = idx;
        found     = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/msg_sim_scheduler.sv
// msg_sim_scheduler - frame sequencer for the message-transmit sim generator (rev 1.0)
// Define MSG_SIM_SCHED_TIMEOUT_EN to enable the RUN-state watchdog.
`default_nettype none

module msg_sim_scheduler
  import msg_sim_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int PERIOD_W    = 32
) (
  input  logic                sys_clk_i,
  input  logic                rst_n_i,
  input  logic                cfg_start_i,
  input  logic                cfg_stop_i,
  input  logic [15:0]         cfg_frame_num_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  input  logic [7:0]          cfg_chan_mask_i,
  input  logic [15:0]         cfg_frame_cnt_init_i,
  input  logic                msg_state_done_pluse_i,
  output logic                msg_sim_en_o,
  output logic [15:0]         sim_frame_cnt_o,
  output logic [7:0]          sim_data_channel_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                cfg_err_o,
  output logic                timeout_err_o
);

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_t                state;
  logic [15:0]           frame_num_lat;
  logic [PERIOD_W-1:0]   period_lat;
  logic [CHAN_W-1:0]     mask_lat;
  logic [15:0]           sent_cnt;
  logic [PERIOD_W-1:0]   period_cnt;
  logic [15:0]           frame_cnt;
  logic [CHAN_IDX_W-1:0] chan;
  logic                  stop_pend;
  logic                  en;
  logic                  done_pulse;
  logic                  cfg_err;

  logic [CHAN_W-1:0]     rr_mask;
  logic [CHAN_IDX_W-1:0] rr_cur;
  logic [CHAN_IDX_W-1:0] rr_next;
  logic                  last_frame;
  logic                  period_hit;

  // In IDLE, searching above the top channel yields the lowest set bit of the incoming mask.
  assign rr_mask = (state == ST_IDLE) ? cfg_chan_mask_i : mask_lat;
  assign rr_cur  = (state == ST_IDLE) ? CHAN_IDX_W'(CHAN_W - 1) : chan;

  msg_sim_chan_rr u_chan_rr (
    .mask      (rr_mask),
    .cur_chan  (rr_cur),
    .next_chan (rr_next)
  );

  assign last_frame = (frame_num_lat != 16'd0) && ((sent_cnt + 16'd1) == frame_num_lat);
  assign period_hit = (period_lat == '0) || (period_cnt >= (period_lat - PERIOD_W'(1)));

`ifdef MSG_SIM_SCHED_TIMEOUT_EN
  localparam int RUN_CNT_W = $clog2(TIMEOUT_CYC);
  logic [RUN_CNT_W-1:0] run_cnt;
  logic                 timeout_err;
  assign timeout_err_o = timeout_err;
`else
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= ST_IDLE;
      frame_num_lat <= '0;
      period_lat    <= '0;
      mask_lat      <= '0;
      sent_cnt      <= '0;
      period_cnt    <= '0;
      frame_cnt     <= '0;
      chan          <= '0;
      stop_pend     <= 1'b0;
      en            <= 1'b0;
      done_pulse    <= 1'b0;
      cfg_err       <= 1'b0;
`ifdef MSG_SIM_SCHED_TIMEOUT_EN
      run_cnt       <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      done_pulse <= 1'b0;
      if (period_cnt != '1) begin
        period_cnt <= period_cnt + PERIOD_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (cfg_start_i && !cfg_stop_i) begin
            if (cfg_chan_mask_i == '0) begin
              cfg_err <= 1'b1;
            end else begin
              frame_num_lat <= cfg_frame_num_i;
              period_lat    <= cfg_period_i;
              mask_lat      <= cfg_chan_mask_i;
              frame_cnt     <= cfg_frame_cnt_init_i;
              chan          <= rr_next;
              sent_cnt      <= '0;
              period_cnt    <= '0;
              stop_pend     <= 1'b0;
              cfg_err       <= 1'b0;
              en            <= 1'b1;
              state         <= ST_RUN;
`ifdef MSG_SIM_SCHED_TIMEOUT_EN
              run_cnt       <= '0;
              timeout_err   <= 1'b0;
`endif
            end
          end
        end
        ST_RUN: begin
          if (cfg_stop_i) begin
            stop_pend <= 1'b1;
          end
          if (msg_state_done_pluse_i) begin
            en        <= 1'b0;
            sent_cnt  <= sent_cnt + 16'd1;
            frame_cnt <= frame_cnt + 16'd1;
            chan      <= rr_next;
            if (last_frame || stop_pend || cfg_stop_i) begin
              done_pulse <= 1'b1;
              state      <= ST_FINISH;
            end else begin
              state <= ST_GAP;
            end
          end
`ifdef MSG_SIM_SCHED_TIMEOUT_EN
          else if (run_cnt == RUN_CNT_W'(TIMEOUT_CYC - 1)) begin
            en          <= 1'b0;
            timeout_err <= 1'b1;
            done_pulse  <= 1'b1;
            state       <= ST_FINISH;
          end else begin
            run_cnt <= run_cnt + RUN_CNT_W'(1);
          end
`endif
        end
        ST_GAP: begin
          if (cfg_stop_i) begin
            done_pulse <= 1'b1;
            state      <= ST_FINISH;
          end else if (period_hit) begin
            period_cnt <= '0;
            en         <= 1'b1;
            state      <= ST_RUN;
`ifdef MSG_SIM_SCHED_TIMEOUT_EN
            run_cnt    <= '0;
`endif
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign msg_sim_en_o       = en;
  assign sim_frame_cnt_o    = frame_cnt;
  assign sim_data_channel_o = {{(8 - CHAN_IDX_W){1'b0}}, chan};
  assign busy_o             = (state != ST_IDLE);
  assign done_o             = done_pulse;
  assign cfg_err_o          = cfg_err;

endmodule

`default_nettype wire
